// File: rtl/vreg_xbar_burst.sv
// vreg_xbar_burst: NUM_PORT lane ports to NUM_VREG vector-register banks.
// Each bank has a round-robin arbiter that locks onto one port for a whole
// multi-beat burst. Accepted beats are registered onto the bank command
// outputs. Read data is routed back to the issuing port by a tag pipeline
// that runs alongside the bank read latency.
//
// Ports (per-port and per-bank fields are packed side by side, index 0 at the LSBs):
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_vld_i          per-port request valid
//   req_vreg_i         per-port target bank (VW bits each)
//   req_write_i        per-port write (1) / read (0)
//   req_addr_i         per-port beat address (AW bits each)
//   req_data_i         per-port write data (VREG_WIDTH bits each)
//   req_len_i          per-port beats-1, used on the first beat only
//   req_gnt_o          per-port beat accepted this cycle (combinational)
//   bank_en_o/we_o     per-bank registered command valid / write enable
//   bank_addr_o        per-bank registered address
//   bank_wdata_o       per-bank registered write data
//   bank_rdata_i       per-bank read data, RD_LAT cycles after the command
//   rsp_vld_o          per-port read response pulse
//   rsp_data_o         per-port read data (holds between pulses)
//   rsp_vreg_o         per-port bank that produced rsp_data_o
module vreg_xbar_burst #(
  parameter int NUM_PORT   = 4,
  parameter int NUM_VREG   = 8,
  parameter int VREG_DEPTH = 64,
  parameter int VREG_WIDTH = 64,
  parameter int LEN_W      = 4,
  parameter int RD_LAT     = 1,
  localparam int AW = $clog2(VREG_DEPTH),
  localparam int VW = $clog2(NUM_VREG),
  localparam int PW = $clog2(NUM_PORT)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_PORT-1:0]            req_vld_i,
  input  logic [NUM_PORT*VW-1:0]         req_vreg_i,
  input  logic [NUM_PORT-1:0]            req_write_i,
  input  logic [NUM_PORT*AW-1:0]         req_addr_i,
  input  logic [NUM_PORT*VREG_WIDTH-1:0] req_data_i,
  input  logic [NUM_PORT*LEN_W-1:0]      req_len_i,
  output logic [NUM_PORT-1:0]            req_gnt_o,
  output logic [NUM_VREG-1:0]            bank_en_o,
  output logic [NUM_VREG-1:0]            bank_we_o,
  output logic [NUM_VREG*AW-1:0]         bank_addr_o,
  output logic [NUM_VREG*VREG_WIDTH-1:0] bank_wdata_o,
  input  logic [NUM_VREG*VREG_WIDTH-1:0] bank_rdata_i,
  output logic [NUM_PORT-1:0]            rsp_vld_o,
  output logic [NUM_PORT*VREG_WIDTH-1:0] rsp_data_o,
  output logic [NUM_PORT*VW-1:0]         rsp_vreg_o
);

  // GAP is the single ungranted cycle that follows a completed burst.
  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_e;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) == NUM_PORT - 1) return '0;
    return p + PW'(1);
  endfunction

  // Per-port views of the packed request buses.
  logic [VW-1:0]         p_vreg  [NUM_PORT];
  logic [AW-1:0]         p_addr  [NUM_PORT];
  logic [VREG_WIDTH-1:0] p_data  [NUM_PORT];
  logic [LEN_W-1:0]      p_len   [NUM_PORT];

  logic [NUM_VREG*NUM_PORT-1:0] bank_gnt;
  logic [NUM_VREG-1:0]          tag_vld;
  logic [NUM_VREG*PW-1:0]       tag_port;

  for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_unpack
    assign p_vreg[gi] = req_vreg_i[gi*VW +: VW];
    assign p_addr[gi] = req_addr_i[gi*AW +: AW];
    assign p_data[gi] = req_data_i[gi*VREG_WIDTH +: VREG_WIDTH];
    assign p_len[gi]  = req_len_i[gi*LEN_W +: LEN_W];
  end

  // A port only ever targets one bank, so OR-ing the bank grants is safe.
  // Grants are forced low while reset is asserted.
  always_comb begin
    req_gnt_o = '0;
    for (int b = 0; b < NUM_VREG; b++) begin
      req_gnt_o = req_gnt_o | bank_gnt[b*NUM_PORT +: NUM_PORT];
    end
    req_gnt_o = req_gnt_o & {NUM_PORT{rst_ni}};
  end

  for (genvar gi = 0; gi < NUM_VREG; gi++) begin : g_bank
    state_e                state_q;
    logic [PW-1:0]         ptr_q, owner_q, port_q;
    logic [LEN_W-1:0]      cnt_q;
    logic                  en_q, we_q;
    logic [AW-1:0]         addr_q;
    logic [VREG_WIDTH-1:0] wdata_q;
    logic [NUM_PORT-1:0]   cand, gnt;
    logic [PW-1:0]         win, sel;
    logic                  win_vld, beat;
    logic [RD_LAT-1:0]     tv_q;
    logic [PW-1:0]         tp_q [RD_LAT];

    for (genvar gj = 0; gj < NUM_PORT; gj++) begin : g_cand
      assign cand[gj] = req_vld_i[gj] && (p_vreg[gj] == VW'(gi));
    end

    // First candidate at or after ptr_q with wrap: scanning from the far
    // end lets the nearest hit overwrite the others.
    always_comb begin
      int idx;
      idx     = 0;
      win     = ptr_q;
      win_vld = 1'b0;
      for (int k = NUM_PORT - 1; k >= 0; k--) begin
        idx = (int'(ptr_q) + k) % NUM_PORT;
        if (cand[idx]) begin
          win     = PW'(idx);
          win_vld = 1'b1;
        end
      end
    end

    always_comb begin
      gnt  = '0;
      beat = 1'b0;
      sel  = owner_q;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            gnt[win] = 1'b1;
            beat     = 1'b1;
            sel      = win;
          end
        end
        S_BURST: begin
          if (cand[owner_q]) begin
            gnt[owner_q] = 1'b1;
            beat         = 1'b1;
          end
        end
        default: ;
      endcase
    end

    assign bank_gnt[gi*NUM_PORT +: NUM_PORT] = gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= S_IDLE;
        ptr_q   <= '0;
        owner_q <= '0;
        cnt_q   <= '0;
        en_q    <= 1'b0;
        we_q    <= 1'b0;
        addr_q  <= '0;
        wdata_q <= '0;
        port_q  <= '0;
      end else begin
        en_q <= beat;
        we_q <= beat & req_write_i[sel];
        if (beat) begin
          addr_q  <= p_addr[sel];
          wdata_q <= p_data[sel];
          port_q  <= sel;
        end
        case (state_q)
          S_IDLE: begin
            if (win_vld) begin
              owner_q <= win;
              cnt_q   <= p_len[win];
              if (p_len[win] == '0) ptr_q <= ptr_inc(win);
              else                  state_q <= S_BURST;
            end
          end
          S_BURST: begin
            if (cand[owner_q]) begin
              cnt_q <= cnt_q - LEN_W'(1);
              if (cnt_q == LEN_W'(1)) begin
                state_q <= S_GAP;
                ptr_q   <= ptr_inc(owner_q);
              end
            end else begin
              // Abort: this cycle is already the ungranted gap.
              state_q <= S_IDLE;
              ptr_q   <= ptr_inc(owner_q);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end

    // Read tags enter as the command leaves, so the last stage lines up
    // with bank_rdata_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        tv_q <= '0;
        for (int i = 0; i < RD_LAT; i++) tp_q[i] <= '0;
      end else begin
        tv_q[0] <= en_q & ~we_q;
        tp_q[0] <= port_q;
        for (int i = 1; i < RD_LAT; i++) begin
          tv_q[i] <= tv_q[i-1];
          tp_q[i] <= tp_q[i-1];
        end
      end
    end

    assign tag_vld[gi]            = tv_q[RD_LAT-1];
    assign tag_port[gi*PW +: PW]  = tp_q[RD_LAT-1];
    assign bank_en_o[gi]          = en_q;
    assign bank_we_o[gi]          = we_q;
    assign bank_addr_o[gi*AW +: AW] = addr_q;
    assign bank_wdata_o[gi*VREG_WIDTH +: VREG_WIDTH] = wdata_q;
  end

  for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_rsp
    logic                  hit;
    logic [VREG_WIDTH-1:0] hit_data;
    logic [VW-1:0]         hit_vreg;
    logic                  vld_q;
    logic [VREG_WIDTH-1:0] data_q;
    logic [VW-1:0]         vreg_q;

    // At most one bank can carry a tag for this port in any cycle.
    always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      hit_vreg = '0;
      for (int b = 0; b < NUM_VREG; b++) begin
        if (tag_vld[b] && (tag_port[b*PW +: PW] == PW'(gi))) begin
          hit      = 1'b1;
          hit_data = bank_rdata_i[b*VREG_WIDTH +: VREG_WIDTH];
          hit_vreg = VW'(b);
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        vreg_q <= '0;
      end else begin
        vld_q <= hit;
        if (hit) begin
          data_q <= hit_data;
          vreg_q <= hit_vreg;
        end
      end
    end

    assign rsp_vld_o[gi]                         = vld_q;
    assign rsp_data_o[gi*VREG_WIDTH +: VREG_WIDTH] = data_q;
    assign rsp_vreg_o[gi*VW +: VW]               = vreg_q;
  end

endmodule

// File: tb/tb_vreg_xbar_burst.sv
module tb_vreg_xbar_burst;
  localparam int NP = 4, NV = 8, DEPTH = 64, W = 64, LW = 4, RL = 1;
  localparam int AW = 6, VW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0]    req_vld = '0, req_write = '0;
  logic [NP*VW-1:0] req_vreg = '0;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP*W-1:0]  req_data = '0;
  logic [NP*LW-1:0] req_len = '0;
  logic [NP-1:0]    req_gnt, rsp_vld;
  logic [NV-1:0]    bank_en, bank_we;
  logic [NV*AW-1:0] bank_addr;
  logic [NV*W-1:0]  bank_wdata, bank_rdata;
  logic [NP*W-1:0]  rsp_data;
  logic [NP*VW-1:0] rsp_vreg;

  vreg_xbar_burst #(.NUM_PORT(NP), .NUM_VREG(NV), .VREG_DEPTH(DEPTH),
                    .VREG_WIDTH(W), .LEN_W(LW), .RD_LAT(RL)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_vld_i(req_vld), .req_vreg_i(req_vreg), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_len_i(req_len),
    .req_gnt_o(req_gnt),
    .bank_en_o(bank_en), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
    .bank_wdata_o(bank_wdata), .bank_rdata_i(bank_rdata),
    .rsp_vld_o(rsp_vld), .rsp_data_o(rsp_data), .rsp_vreg_o(rsp_vreg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank read data: a fixed pattern of bank and address, RL cycles after the command.
  function automatic logic [W-1:0] pat(input int b, input int a);
    return {16'hB000 + 16'(b), 16'hA000 + 16'(a), 32'h1234_5678};
  endfunction

  function automatic logic [W-1:0] wdat(input int p, input int a);
    return {32'hD0D0_0000 + 32'(p), 32'(a)};
  endfunction

  logic [W-1:0] rd_pipe [NV][RL];
  always @(posedge clk) begin
    for (int b = 0; b < NV; b++) begin
      if (bank_en[b]) rd_pipe[b][0] <= pat(b, int'(bank_addr[b*AW +: AW]));
      for (int i = 1; i < RL; i++) rd_pipe[b][i] <= rd_pipe[b][i-1];
    end
  end
  always_comb begin
    bank_rdata = '0;
    for (int b = 0; b < NV; b++) bank_rdata[b*W +: W] = rd_pipe[b][RL-1];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0]  data;
    logic [VW-1:0] vreg;
    int            cyc;
  } exp_t;
  exp_t sbq [NP][$];

  // Response monitor: pops the port's queue on every rsp_vld pulse.
  exp_t me;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < NP; p++) begin
        if (rsp_vld[p]) begin
          if (sbq[p].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: port %0d got rsp_vld=1 expected 0 (cycle %0d)", p, cyc);
          end else begin
            me = sbq[p].pop_front();
            $display("[TB] rsp port %0d vreg %0d data %h cycle %0d", p,
                     rsp_vreg[p*VW +: VW], rsp_data[p*W +: W], cyc);
            chk($sformatf("rsp_data p%0d", p), rsp_data[p*W +: W], me.data);
            chk($sformatf("rsp_vreg p%0d", p), 64'(rsp_vreg[p*VW +: VW]), 64'(me.vreg));
            chk($sformatf("rsp_cycle p%0d", p), 64'(cyc), 64'(me.cyc));
          end
        end
      end
    end
  end

  // Command expected on the bank outputs in the cycle after a grant.
  logic [NV-1:0] pend_en = '0, pend_we = '0;
  logic [AW-1:0] pend_addr [NV];
  logic [W-1:0]  pend_wd   [NV];

  task automatic setp(input int p, input logic v, input int b, input logic w,
                      input int a, input int l);
    req_vld[p]              = v;
    req_vreg[p*VW +: VW]    = VW'(b);
    req_write[p]            = w;
    req_addr[p*AW +: AW]    = AW'(a);
    req_len[p*LW +: LW]     = LW'(l);
    req_data[p*W +: W]      = wdat(p, a);
  endtask

  task automatic step(input logic [NP-1:0] eg, input string nm);
    int b;
    @(negedge clk);
    $display("[TB] %s cycle %0d gnt %b bank_en %b bank_we %b", nm, cyc, req_gnt, bank_en, bank_we);
    chk({nm, " gnt"}, 64'(req_gnt), 64'(eg));
    chk({nm, " bank_en"}, 64'(bank_en), 64'(pend_en));
    chk({nm, " bank_we"}, 64'(bank_we), 64'(pend_we));
    for (int k = 0; k < NV; k++) begin
      if (pend_en[k]) begin
        chk($sformatf("%s bank_addr%0d", nm, k), 64'(bank_addr[k*AW +: AW]), 64'(pend_addr[k]));
        if (pend_we[k]) chk($sformatf("%s bank_wdata%0d", nm, k), bank_wdata[k*W +: W], pend_wd[k]);
      end
    end
    pend_en = '0;
    pend_we = '0;
    for (int p = 0; p < NP; p++) begin
      if (eg[p]) begin
        b = int'(req_vreg[p*VW +: VW]);
        pend_en[b]   = 1'b1;
        pend_we[b]   = req_write[p];
        pend_addr[b] = req_addr[p*AW +: AW];
        pend_wd[b]   = req_data[p*W +: W];
        if (!req_write[p])
          sbq[p].push_back('{data: pat(b, int'(req_addr[p*AW +: AW])),
                             vreg: VW'(b), cyc: cyc + RL + 2});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input int n);
    repeat (n) begin
      for (int p = 0; p < NP; p++) begin
        req_vld[p] = 1'($urandom);
        req_write[p] = 1'($urandom);
        req_vreg[p*VW +: VW] = VW'($urandom);
        req_addr[p*AW +: AW] = AW'($urandom);
        req_len[p*LW +: LW] = LW'($urandom);
        req_data[p*W +: W] = {$urandom, $urandom};
      end
      @(negedge clk);
      $display("[TB] reset cycle %0d gnt %b bank_en %b rsp_vld %b", cyc, req_gnt, bank_en, rsp_vld);
      chk("reset ctrl outs", 64'({req_gnt, bank_en, bank_we, rsp_vld}), 64'(0));
      chk("reset data outs", 64'(|{bank_addr, bank_wdata, rsp_data, rsp_vreg}), 64'(0));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_all();
    req_vld = '0;
    req_write = '0;
  endtask

  initial begin
    // 1: reset, then a single read
    rst_n = 1'b0;
    reset_check(4);
    clr_all();
    rst_n = 1'b1;
    setp(0, 1, 3, 0, 5, 0);
    step(4'b0001, "t1 grant");
    clr_all();
    step(4'b0000, "t1 cmd");
    repeat (3) step(4'b0000, "t1 wait");

    // 2: four ports round-robin on bank 2
    for (int p = 0; p < NP; p++) setp(p, 1, 2, 0, 20 + p, 0);
    step(4'b0001, "t2 rr0");
    step(4'b0010, "t2 rr1");
    step(4'b0100, "t2 rr2");
    step(4'b1000, "t2 rr3");
    step(4'b0001, "t2 rr0b");
    clr_all();
    step(4'b0000, "t2 end");

    // 3: port1 write burst of 4 locks bank 0, port2 waits out the gap
    setp(1, 1, 0, 1, 10, 3);
    setp(2, 1, 0, 0, 30, 0);
    step(4'b0010, "t3 beat0");
    setp(1, 1, 0, 1, 11, 0);
    step(4'b0010, "t3 beat1");
    setp(1, 1, 0, 1, 12, 0);
    step(4'b0010, "t3 beat2");
    setp(1, 1, 0, 1, 13, 0);
    step(4'b0010, "t3 beat3");
    req_vld[1] = 1'b0;
    step(4'b0000, "t3 gap");
    step(4'b0100, "t3 port2");
    clr_all();
    step(4'b0000, "t3 end");

    // 4: port0 burst on bank 1 aborts after two beats
    setp(0, 1, 1, 0, 40, 7);
    setp(3, 1, 1, 0, 50, 0);
    step(4'b0001, "t4 beat0");
    setp(0, 1, 1, 0, 41, 7);
    step(4'b0001, "t4 beat1");
    req_vld[0] = 1'b0;
    step(4'b0000, "t4 abort");
    setp(0, 1, 1, 0, 42, 0);
    step(4'b1000, "t4 port3");
    req_vld[3] = 1'b0;
    step(4'b0001, "t4 port0");
    clr_all();
    step(4'b0000, "t4 end");

    // 5: four banks in parallel
    for (int p = 0; p < NP; p++) setp(p, 1, p, 0, p + 1, 0);
    step(4'b1111, "t5 parallel");
    clr_all();
    repeat (4) step(4'b0000, "t5 wait");

    // 6: reset with a burst and reads in flight
    setp(1, 1, 5, 0, 7, 0);
    step(4'b0010, "t6 p1");
    clr_all();
    step(4'b0000, "t6 idle");
    setp(2, 1, 5, 0, 8, 3);
    step(4'b0100, "t6 beat0");
    setp(2, 1, 5, 0, 9, 3);
    step(4'b0100, "t6 beat1");
    rst_n = 1'b0;
    pend_en = '0;
    pend_we = '0;
    for (int p = 0; p < NP; p++) sbq[p].delete();
    reset_check(2);
    clr_all();
    rst_n = 1'b1;
    for (int p = 0; p < NP; p++) setp(p, 1, 5, 0, p, 0);
    step(4'b0001, "t6 ptr0");
    clr_all();
    repeat (5) step(4'b0000, "t6 wait");

    for (int p = 0; p < NP; p++) chk($sformatf("sb empty p%0d", p), 64'(sbq[p].size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
